pipe_field: RTL and testbench
=============================

# pipe_field

Multi-channel obstacle generator for the Flappy game core. It scrolls up to NUM_PIPES pipes right-to-left across the 800x525 playfield at a programmable, run-time selectable speed. It spawns pipes at a fixed pixel spacing with pseudo-random gap heights, and counts pipes passing the bird column. It sits between the game-state controller (Start/Freeze) and the VGA renderer and collision checker, which consume the packed position outputs.

## Interface
- NUM_PIPES, 3: number of pipe channels (1..8).
- TICK_DIV, 500000: clocks per move tick (>=2).
- START_DELAY, 512: move ticks spent in ARM before the first spawn.
- X_START, 1000: spawn X coordinate.
- SPACING, 334: move ticks between spawns.
- BIRD_X, 200: bird column used for pass detection.
- Y_MIN, 20: minimum gap Y.
- Y_MASK, 255: AND-mask applied to the LFSR for the gap offset.
- Y_IDLE, 200: Y value shown while idle.
- LFSR_SEED, 8'hA5: nonzero LFSR reset value.
- Clk  in  1  system clock; single clock domain.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  level: game running; low returns the block to IDLE.
- Freeze  in  1  level: bird lost; freezes the field until Start drops.
- SpeedLevel  in  2  pixels per move tick = SpeedLevel+1; sampled on each tick.
- PipePosX  out  10*NUM_PIPES  pipe k X at [10k+:10].
- PipePosY  out  10*NUM_PIPES  pipe k gap Y at [10k+:10].
- PipeValid  out  NUM_PIPES  pipe k active (renderer/collision ignore inactive).
- Tick  out  1  one-cycle move-tick strobe; asserted only in ARM/RUN.
- Passed  out  1  one-cycle pulse on any tick where >=1 pipe crossed BIRD_X.
- Score  out  10  pipes passed since last Start; saturates at 1023.

## Operation
- States:
  - IDLE: all pipes invalid; X=X_START, Y=Y_IDLE; prescaler held at 0.
  - ARM: count ticks.
  - RUN: move, spawn, retire.
  - FROZEN: hold everything; prescaler stops and Tick stays low.
- Transitions (priority order):
  - Reset -> IDLE.
  - !Start -> IDLE from any state.
  - IDLE & Start -> ARM. On this edge: Score=0, delay counter=0, prescaler=0, spawn counter=0.
  - ARM/RUN & Freeze -> FROZEN.
  - ARM -> RUN on the tick where the delay counter reaches START_DELAY-1.
  - FROZEN is left only via !Start.
- Prescaler counts 0..TICK_DIV-1 in ARM/RUN. Tick fires on the cycle where the prescaler equals TICK_DIV-1.
- In RUN, on each tick:
  - Move/retire: each valid pipe with X >= step gets X -= step. A valid pipe with X < step becomes invalid, keeps its X, and does not count as passed.
  - Pass: a pipe passes when old X > BIRD_X and new X <= BIRD_X. Score += number of passes that tick (saturating). Passed pulses if count>0.
  - Spawn: if the spawn counter == 0, the lowest-index pipe that was invalid before this tick gets valid=1, X=X_START, Y=Y_MIN+(lfsr&Y_MASK), and the counter reloads to SPACING-1. Otherwise the counter decrements.
  - If no pipe is free at spawn time, the spawn is dropped and the counter still reloads.
  - A pipe retiring this tick is not spawn-eligible until the next tick.
  - A pipe spawned this tick is not moved this tick.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Advances every clock unless Reset. Reset loads LFSR_SEED.

## Timing
- All outputs are registered. Updates caused by a tick are visible on the cycle after the Tick strobe edge. Tick, Passed and the Score update are coincident.
- Reset values:
  - state IDLE.
  - PipePosX = X_START per channel; PipePosY = Y_IDLE per channel.
  - PipeValid=0, Tick=0, Passed=0, Score=0, lfsr=LFSR_SEED.
- Reset mid-run takes effect on the next edge, with the same values as above.
- Start low while in RUN clears all pipes on the next edge. Score holds until the next IDLE->ARM edge.
- Steady scroll rate = TICK_DIV*(SPACING) clocks between spawns, independent of SpeedLevel.

## Test plan
Parameters for all scenarios: NUM_PIPES=2, TICK_DIV=4, START_DELAY=2, X_START=20, SPACING=12, BIRD_X=10.
- Reset with Start=0 -> PipeValid=00, PipePosX={20,20}, PipePosY={200,200}, Score=0, Tick never pulses.
- Start=1, SpeedLevel=0 -> ARM for 2 ticks (8 clocks). On the first RUN tick (T0) pipe0 becomes valid at X=20, then decrements 1 per tick: X=19 at T0+1.
- Continue -> pipe0 reaches X=10 at T0+10 with Passed pulse and Score=1. Pipe1 spawns at T0+12 (pipe0 X=8). Pipe0 reaches X=0 at T0+20, goes invalid at T0+21, respawns at X=20 at T0+24.
- SpeedLevel=3 from spawn -> X sequence 20,16,12,8 with one Passed at 12->8, then 4,0, then invalid on the next tick. Score increments exactly once.
- Freeze=1 mid-RUN -> Tick stops and X/Y/Valid/Score hold. Freeze=0 keeps FROZEN. Start=0 -> IDLE. Start=1 again -> Score=0.
- Reset asserted mid-RUN for 1 cycle, Start held high -> all outputs at reset values, then IDLE->ARM, and the first spawn occurs 2 ticks later at X=20.

Source files
------------

// File: rtl/pipe_field.sv
`default_nettype none
// ============================================================================
// Module   : pipe_field
// Purpose  : Multi-channel obstacle generator. Scrolls up to NUM_PIPES pipes
//            right-to-left at a run-time selectable speed, spawns them at a
//            fixed tick spacing with pseudo-random gap heights and counts
//            pipes crossing the bird column.
// Ports    : Clk, Reset (sync, active-high)
//            Start      - level, game running (low -> IDLE)
//            Freeze     - level, freeze field until Start drops
//            SpeedLevel - pixels per move tick minus one
//            PipePosX/PipePosY - packed 10-bit X / gap Y per pipe
//            PipeValid  - pipe active flags
//            Tick       - one-cycle move-tick strobe
//            Passed     - one-cycle pulse when any pipe crossed BIRD_X
//            Score      - saturating pass count since last Start
// Revision : 1.0 - initial release
// ============================================================================
module pipe_field #(
    parameter int         NUM_PIPES   = 3,
    parameter int         TICK_DIV    = 500000,
    parameter int         START_DELAY = 512,
    parameter int         X_START     = 1000,
    parameter int         SPACING     = 334,
    parameter int         BIRD_X      = 200,
    parameter int         Y_MIN       = 20,
    parameter int         Y_MASK      = 255,
    parameter int         Y_IDLE      = 200,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      Start,
    input  logic                      Freeze,
    input  logic [1:0]                SpeedLevel,
    output logic [10*NUM_PIPES-1:0]   PipePosX,
    output logic [10*NUM_PIPES-1:0]   PipePosY,
    output logic [NUM_PIPES-1:0]      PipeValid,
    output logic                      Tick,
    output logic                      Passed,
    output logic [9:0]                Score
);

    localparam int c_PW = $clog2(TICK_DIV);
    localparam int c_DW = $clog2(START_DELAY + 1);
    localparam int c_SW = $clog2(SPACING + 1);

    localparam logic [c_PW-1:0] c_PRESC_MAX    = c_PW'(TICK_DIV - 1);
    localparam logic [c_DW-1:0] c_DELAY_MAX    = c_DW'(START_DELAY - 1);
    localparam logic [c_SW-1:0] c_SPAWN_RELOAD = c_SW'(SPACING - 1);
    localparam logic [9:0]      c_X_START      = 10'(X_START);
    localparam logic [9:0]      c_Y_IDLE       = 10'(Y_IDLE);
    localparam logic [9:0]      c_Y_MIN        = 10'(Y_MIN);
    localparam logic [9:0]      c_BIRD_X       = 10'(BIRD_X);
    localparam logic [7:0]      c_Y_MASK       = 8'(Y_MASK);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARM    = 2'd1,
        S_RUN    = 2'd2,
        S_FROZEN = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_PW-1:0]        r_presc;
    logic [c_DW-1:0]        r_delay;
    logic [c_SW-1:0]        r_spawn_cnt;
    logic [7:0]             r_lfsr;
    logic [9:0]             r_x [NUM_PIPES];
    logic [9:0]             r_y [NUM_PIPES];
    logic [NUM_PIPES-1:0]   r_valid;
    logic                   r_tick;
    logic                   r_passed;
    logic [9:0]             r_score;

    logic                   w_active;
    logic                   w_tick;
    logic                   w_arm_done;
    logic [9:0]             w_step;
    logic [9:0]             w_x_nxt [NUM_PIPES];
    logic [NUM_PIPES-1:0]   w_valid_nxt;
    logic [NUM_PIPES-1:0]   w_pass;
    logic [NUM_PIPES-1:0]   w_spawn_sel;
    logic                   w_spawn_now;
    logic                   w_taken;
    logic [3:0]             w_pass_cnt;
    logic [10:0]            w_score_sum;
    logic [9:0]             w_score_nxt;
    logic [9:0]             w_y_spawn;

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_active    = (r_state == S_ARM) || (r_state == S_RUN);
        w_tick      = w_active && (r_presc == c_PRESC_MAX);
        w_arm_done  = (r_state == S_ARM) && w_tick && (r_delay == c_DELAY_MAX);
        w_state_nxt = r_state;
        if (!Start) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   w_state_nxt = S_ARM;
                S_ARM:    begin
                    if (Freeze)          w_state_nxt = S_FROZEN;
                    else if (w_arm_done) w_state_nxt = S_RUN;
                end
                S_RUN:    begin
                    if (Freeze)          w_state_nxt = S_FROZEN;
                end
                default:  w_state_nxt = S_FROZEN;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Per-tick pipe update. Spawn eligibility looks at the valid flags from
    // before the tick, so a pipe retiring now cannot be reused until the
    // next tick, and a freshly spawned pipe is never moved on its own tick.
    // ------------------------------------------------------------------
    always_comb begin
        w_step      = 10'(SpeedLevel) + 10'd1;
        w_spawn_now = (r_spawn_cnt == '0);
        w_taken     = 1'b0;
        w_pass_cnt  = '0;
        w_y_spawn   = c_Y_MIN + {2'b00, r_lfsr & c_Y_MASK};
        for (int k = 0; k < NUM_PIPES; k++) begin
            w_x_nxt[k]     = r_x[k];
            w_valid_nxt[k] = r_valid[k];
            w_pass[k]      = 1'b0;
            w_spawn_sel[k] = 1'b0;
            if (r_valid[k]) begin
                if (r_x[k] >= w_step) begin
                    w_x_nxt[k] = r_x[k] - w_step;
                    w_pass[k]  = (r_x[k] > c_BIRD_X) && ((r_x[k] - w_step) <= c_BIRD_X);
                end else begin
                    // Retire in place; X is left where it was.
                    w_valid_nxt[k] = 1'b0;
                end
            end else if (w_spawn_now && !w_taken) begin
                w_spawn_sel[k] = 1'b1;
                w_taken        = 1'b1;
                w_x_nxt[k]     = c_X_START;
                w_valid_nxt[k] = 1'b1;
            end
            w_pass_cnt = w_pass_cnt + 4'(w_pass[k]);
        end
        w_score_sum = 11'(r_score) + 11'(w_pass_cnt);
        w_score_nxt = (w_score_sum > 11'd1023) ? 10'd1023 : w_score_sum[9:0];
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_presc     <= '0;
            r_delay     <= '0;
            r_spawn_cnt <= '0;
            r_valid     <= '0;
            r_tick      <= 1'b0;
            r_passed    <= 1'b0;
            r_score     <= '0;
            for (int k = 0; k < NUM_PIPES; k++) begin
                r_x[k] <= c_X_START;
                r_y[k] <= c_Y_IDLE;
            end
        end else if (!Start) begin
            // Score is deliberately kept so the final result stays visible.
            r_presc  <= '0;
            r_valid  <= '0;
            r_tick   <= 1'b0;
            r_passed <= 1'b0;
            for (int k = 0; k < NUM_PIPES; k++) begin
                r_x[k] <= c_X_START;
                r_y[k] <= c_Y_IDLE;
            end
        end else if (r_state == S_IDLE) begin
            r_score     <= '0;
            r_delay     <= '0;
            r_presc     <= '0;
            r_spawn_cnt <= '0;
            r_tick      <= 1'b0;
            r_passed    <= 1'b0;
        end else if (w_active && !Freeze) begin
            r_presc  <= w_tick ? '0 : r_presc + c_PW'(1);
            r_tick   <= w_tick;
            r_passed <= 1'b0;
            if (w_tick && (r_state == S_ARM)) begin
                r_delay <= r_delay + c_DW'(1);
            end
            if (w_tick && (r_state == S_RUN)) begin
                r_valid  <= w_valid_nxt;
                r_passed <= |w_pass;
                r_score  <= w_score_nxt;
                // Reload happens even when no channel was free.
                r_spawn_cnt <= w_spawn_now ? c_SPAWN_RELOAD : r_spawn_cnt - c_SW'(1);
                for (int k = 0; k < NUM_PIPES; k++) begin
                    r_x[k] <= w_x_nxt[k];
                    if (w_spawn_sel[k]) begin
                        r_y[k] <= w_y_spawn;
                    end
                end
            end
        end else begin
            // FROZEN, or the cycle Freeze is first seen: hold the field.
            r_tick   <= 1'b0;
            r_passed <= 1'b0;
        end
    end

    // Fibonacci LFSR, taps 8,6,5,4; free-running outside reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end

    // ------------------------------------------------------------------
    // Output packing
    // ------------------------------------------------------------------
    generate
        for (genvar g = 0; g < NUM_PIPES; g++) begin : g_pack
            assign PipePosX[10*g +: 10] = r_x[g];
            assign PipePosY[10*g +: 10] = r_y[g];
        end
    endgenerate

    assign PipeValid = r_valid;
    assign Tick      = r_tick;
    assign Passed    = r_passed;
    assign Score     = r_score;

endmodule
`default_nettype wire

// File: tb/tb_pipe_field.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_field
// Purpose  : Self-checking bench for pipe_field (2 pipes, TICK_DIV=4,
//            START_DELAY=2, X_START=20, SPACING=12, BIRD_X=10). Per-tick
//            expectations come from a vector table fed through a scoreboard
//            queue; freeze, restart and mid-run reset are hand sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_field;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic        Freeze;
    logic [1:0]  SpeedLevel;
    logic [19:0] PipePosX;
    logic [19:0] PipePosY;
    logic [1:0]  PipeValid;
    logic        Tick;
    logic        Passed;
    logic [9:0]  Score;

    always #5 Clk = ~Clk;

    pipe_field #(
        .NUM_PIPES   (2),
        .TICK_DIV    (4),
        .START_DELAY (2),
        .X_START     (20),
        .SPACING     (12),
        .BIRD_X      (10)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Freeze     (Freeze),
        .SpeedLevel (SpeedLevel),
        .PipePosX   (PipePosX),
        .PipePosY   (PipePosY),
        .PipeValid  (PipeValid),
        .Tick       (Tick),
        .Passed     (Passed),
        .Score      (Score)
    );

    typedef struct {
        logic [1:0] speed;
        int         valid;
        int         x0;
        int         x1;
        int         passed;
        int         score;
        int         spawn;   // pipe index spawned on this tick, -1 if none
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_y[2];

    // Reference LFSR: x^8+x^6+x^5+x^4, shift left, feedback into bit 0.
    logic [7:0] m_lfsr;
    logic [7:0] m_lfsr_prev;
    always @(posedge Clk) begin
        m_lfsr_prev <= m_lfsr;
        if (Reset) m_lfsr <= 8'hA5;
        else       m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] sp, input int v, input int x0, input int x1,
                       input int p, input int sc, input int spn);
        vec_t e;
        e.speed = sp; e.valid = v; e.x0 = x0; e.x1 = x1;
        e.passed = p; e.score = sc; e.spawn = spn;
        tbl.push_back(e);
    endtask

    // Waits (bounded) for the next Tick strobe, sampled on negedges.
    task automatic wait_tick(output bit ok, output int cyc);
        ok  = 1'b0;
        cyc = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge Clk);
            cyc++;
            if (Tick) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_state(input string tag, input int v, input int x0, input int x1,
                               input int sc);
        check({tag, ".valid"}, int'(PipeValid), v);
        check({tag, ".x0"}, int'(PipePosX[9:0]), x0);
        check({tag, ".x1"}, int'(PipePosX[19:10]), x1);
        check({tag, ".y0"}, int'(PipePosY[9:0]), exp_y[0]);
        check({tag, ".y1"}, int'(PipePosY[19:10]), exp_y[1]);
        check({tag, ".score"}, int'(Score), sc);
    endtask

    task automatic run_vecs(input int first, input int last, input bit chk_latency);
        bit   ok;
        int   cyc;
        vec_t e;
        for (int i = first; i <= last; i++) begin
            SpeedLevel = tbl[i].speed;
            sb.push_back(tbl[i]);
            wait_tick(ok, cyc);
            e = sb.pop_front();
            if (!ok) begin
                n_tests++;
                n_fail++;
                $display("FAIL vec%0d: no Tick within 16 cycles", i);
                continue;
            end
            if (chk_latency && i == first) check("first_tick_latency", cyc, 5);
            if (e.spawn >= 0) exp_y[e.spawn] = 20 + int'(m_lfsr_prev);
            check_state($sformatf("vec%0d", i), e.valid, e.x0, e.x1, e.score);
            check($sformatf("vec%0d.passed", i), int'(Passed), e.passed);
            if (e.passed != 0) begin
                @(negedge Clk);
                check($sformatf("vec%0d.passed_pulse", i), int'(Passed), 0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ticks;

        // ---------------- vector table ----------------
        // Segment A (0..30): first run, speed 0 then speed 3.
        add(0, 0, 20, 20, 0, 0, -1);            // ARM tick 1
        add(0, 0, 20, 20, 0, 0, -1);            // ARM tick 2
        add(0, 1, 20, 20, 0, 0,  0);            // T0 spawn pipe0
        for (int k = 1; k <= 9; k++) add(0, 1, 20 - k, 20, 0, 0, -1);
        add(0, 1, 10, 20, 1, 1, -1);            // T0+10 pass
        add(0, 1,  9, 20, 0, 1, -1);
        add(0, 3,  8, 20, 0, 1,  1);            // T0+12 spawn pipe1
        for (int k = 13; k <= 20; k++) add(0, 3, 20 - k, 32 - k, 0, 1, -1);
        add(0, 2,  0, 11, 0, 1, -1);            // T0+21 pipe0 retired
        add(0, 2,  0, 10, 1, 2, -1);            // T0+22 pipe1 pass
        add(0, 2,  0,  9, 0, 2, -1);
        add(0, 3, 20,  8, 0, 2,  0);            // T0+24 respawn pipe0
        add(3, 3, 16,  4, 0, 2, -1);
        add(3, 3, 12,  0, 0, 2, -1);
        add(3, 1,  8,  0, 1, 3, -1);            // pipe0 pass, pipe1 retired
        add(3, 1,  4,  0, 0, 3, -1);
        // Segment B (31..35): restart after freeze.
        add(0, 0, 20, 20, 0, 0, -1);
        add(0, 0, 20, 20, 0, 0, -1);
        add(0, 1, 20, 20, 0, 0,  0);
        add(0, 1, 19, 20, 0, 0, -1);
        add(0, 1, 18, 20, 0, 0, -1);
        // Segment C (36..38): after mid-run reset.
        add(0, 0, 20, 20, 0, 0, -1);
        add(0, 0, 20, 20, 0, 0, -1);
        add(0, 1, 20, 20, 0, 0,  0);

        exp_y[0] = 200;
        exp_y[1] = 200;

        // ---------------- reset, idle ----------------
        Reset = 1'b1; Start = 1'b0; Freeze = 1'b0; SpeedLevel = 2'd0;
        repeat (3) @(negedge Clk);
        check_state("reset", 0, 20, 20, 0);
        check("reset.tick", int'(Tick), 0);
        Reset = 1'b0;
        ticks = 0;
        repeat (12) begin
            @(negedge Clk);
            if (Tick) ticks++;
        end
        check("idle.no_tick", ticks, 0);
        check_state("idle", 0, 20, 20, 0);

        // ---------------- first run ----------------
        Start = 1'b1;
        run_vecs(0, 30, 1'b1);

        // ---------------- freeze ----------------
        Freeze = 1'b1;
        @(negedge Clk);
        ticks = 0;
        repeat (20) begin
            @(negedge Clk);
            if (Tick) ticks++;
        end
        check("freeze.no_tick", ticks, 0);
        check_state("freeze", 1, 4, 0, 3);
        Freeze = 1'b0;
        ticks = 0;
        repeat (12) begin
            @(negedge Clk);
            if (Tick) ticks++;
        end
        check("unfreeze.no_tick", ticks, 0);
        check_state("unfreeze", 1, 4, 0, 3);

        Start = 1'b0;
        @(negedge Clk);
        exp_y[0] = 200;
        exp_y[1] = 200;
        check_state("stop", 0, 20, 20, 3);

        Start = 1'b1;
        @(negedge Clk);
        check("restart.score", int'(Score), 0);
        // One edge already spent in ARM, so latency is not re-checked here.
        run_vecs(31, 35, 1'b0);

        // ---------------- mid-run reset ----------------
        Reset = 1'b1;
        @(negedge Clk);
        exp_y[0] = 200;
        exp_y[1] = 200;
        check_state("midreset", 0, 20, 20, 0);
        check("midreset.tick", int'(Tick), 0);
        check("midreset.passed", int'(Passed), 0);
        Reset = 1'b0;
        run_vecs(36, 38, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
